seq_u_bam_mul_ctrl: RTL and testbench

- Sequential controller/datapath for an unsigned N x N broken-array (BAM) approximate multiplier.
- Walks the kept partial-product rows one per clock and accumulates them into a 2N-bit product, instead of instantiating the full combinational array.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Results are bit-identical to the combinational h_u_csabam<N>_rca_h<H>_v<V> family for the same N/H/V.

---
 rtl/seq_u_bam_mul_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_u_bam_mul_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_u_bam_mul_ctrl.sv
// Sequential unsigned broken-array (BAM) approximate multiplier: one kept partial-product row per clock.
// Optional exact mode via `define SEQ_U_BAM_MUL_CTRL_EXACT_EN (adds the exact input port).
module seq_u_bam_mul_ctrl #(
    parameter int unsigned N = 8,
    parameter int unsigned H = 6,
    parameter int unsigned V = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
`ifdef SEQ_U_BAM_MUL_CTRL_EXACT_EN
    input  logic            exact,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  out,
    output logic            busy
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned RW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_exact;
    logic [RW-1:0]   w_start_row;
    logic [N-1:0]    w_mask;
    logic [N-1:0]    w_row_bits;
    logic [PW-1:0]   w_row_term;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [PW-1:0]   r_acc;
    logic [RW-1:0]   r_row;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    // Columns kept in row j: bit i survives iff i+j reaches the vertical break.
    function automatic logic [N-1:0] col_mask(input logic [RW-1:0] j);
        logic [N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            m[i] = ((i + 32'(j)) >= V);
        end
        return m;
    endfunction

`ifdef SEQ_U_BAM_MUL_CTRL_EXACT_EN
    logic r_exact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exact <= 1'b0;
        end else if (w_accept) begin
            r_exact <= exact;
        end
    end

    assign w_exact     = r_exact;
    assign w_start_row = exact ? RW'(0) : RW'(H);
`else
    assign w_exact     = 1'b0;
    assign w_start_row = RW'(H);
`endif

    assign w_mask     = w_exact ? {N{1'b1}} : col_mask(r_row);
    assign w_row_bits = r_a & {N{r_b[r_row]}} & w_mask;
    assign w_row_term = PW'(w_row_bits) << r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_row == RW'(N - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and row-by-row accumulation; zero rows still take a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_row <= w_start_row;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_row_term;
            r_row <= r_row + RW'(1);
        end
    end

    // Handshake flags registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out       = r_acc;

endmodule

// File: tb/tb_seq_u_bam_mul_ctrl.sv
// Randomized self-checking bench for seq_u_bam_mul_ctrl against a kept-bit arithmetic model.
// Exercises the exact-mode port when SEQ_U_BAM_MUL_CTRL_EXACT_EN is defined.
module tb_seq_u_bam_mul_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned V  = 11;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned R  = N - H;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          exact;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    seq_u_bam_mul_ctrl #(.N(N), .H(H), .V(V)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_U_BAM_MUL_CTRL_EXACT_EN
        .exact     (exact),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Sum of every kept a[i]&b[j] weighted by 2^(i+j).
    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic ex);
        int unsigned acc;
        acc = 0;
        for (int j = 0; j < int'(N); j++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ((ex || (j >= int'(H) && (i + j) >= int'(V))) && x[i] && y[j]) begin
                    acc += 32'd1 << (i + j);
                end
            end
        end
        return PW'(acc);
    endfunction

    // One full transaction starting at a negedge in IDLE; bp = cycles of held-off out_ready.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tex,
                          input int bp, input logic [PW-1:0] want);
        int lat;
        int exp_lat;
        exp_lat = tex ? int'(N) : int'(R);
        chk("want_vs_model", want, ref_mul(ta, tb_v, tex));
        chk("idle_rdy", in_ready, 1);
        a         = ta;
        b         = tb_v;
        exact     = tex;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        exact    = 1'($urandom);
        chk("run_rdy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("out", out, want);
        chk("done_busy", busy, 1);
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'($urandom);
            a        = N'($urandom);
            b        = N'($urandom);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_out", out, want);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", out_valid, 0);
        chk("post_rdy", in_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    // Accept an operation, then reset on the first RUN cycle.
    task automatic reset_mid(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        chk("rm_idle_rdy", in_ready, 1);
        a         = ta;
        b         = tb_v;
        exact     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_rdy", in_ready, 1);
        chk("rm_valid", out_valid, 0);
        chk("rm_out", out, 0);
        chk("rm_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rm_no_result", out_valid, 0);
        end
    endtask

    task automatic back_to_back();
        logic [PW-1:0] q[$];
        int got;
        int sent;
        int cyc;
        int last_cyc;
        got      = 0;
        sent     = 0;
        cyc      = 0;
        last_cyc = -1;
        exact     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (out_valid) begin
                chk("b2b_pending", q.size() > 0, 1);
                if (q.size() > 0) chk("b2b_out", out, q.pop_front());
                if (last_cyc >= 0) chk("b2b_gap", cyc - last_cyc, 4);
                last_cyc = cyc;
                got++;
            end
            if (in_ready) begin
                if (sent < 4) begin
                    a = N'($urandom);
                    b = N'($urandom);
                    a[7:6] = 2'($urandom | 1);
                    b[7:6] = 2'($urandom | 1);
                    q.push_back(ref_mul(a, b, 1'b0));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 4);
        @(negedge clk);
    endtask

    initial begin
        logic ex;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        exact     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'hFF, 8'hFF, 1'b0, 0, 16'hB000);
        run_op(8'hF0, 8'hC0, 1'b0, 0, 16'hB000);
        run_op(8'h0F, 8'hFF, 1'b0, 0, 16'h0000);
        run_op(8'hFF, 8'h3F, 1'b0, 0, 16'h0000);
        run_op(8'hFF, 8'hFF, 1'b0, 10, 16'hB000);

        reset_mid(8'hFF, 8'hFF);
        back_to_back();

`ifdef SEQ_U_BAM_MUL_CTRL_EXACT_EN
        run_op(8'hFF, 8'hFF, 1'b1, 0, 16'hFE01);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 16'hB000);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = N'($urandom);
`ifdef SEQ_U_BAM_MUL_CTRL_EXACT_EN
            ex = 1'($urandom);
`else
            ex = 1'b0;
`endif
            run_op(ra, rb, ex, int'($urandom_range(0, 3)), ref_mul(ra, rb, ex));
            if (t % 13 == 5) reset_mid(N'($urandom), N'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
